// File: rtl/lc3_io_pkg.sv
// Shared LC-3 memory-mapped I/O definitions, used by the display output and
// keyboard input controllers.
package lc3_io_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CHAR_W          = 8;
  localparam int unsigned DSR_READY_BIT   = 15;
  localparam logic [DATA_W-1:0] DSR_READY_VALUE = 16'h8000;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    SEND      = 3'd2,
    SET_READY = 3'd3,
    SETTLE    = 3'd4
  } io_state_e;

  // Ready flag of a status register value
  function automatic logic sr_ready(input logic [DATA_W-1:0] sr);
    return sr[DSR_READY_BIT];
  endfunction

endpackage

// File: rtl/display_output_if.sv
// CPU-side status/data registers and transmitter handshake of the display
// output controller. slave = the controller, master = its environment.
interface display_output_if;
  import lc3_io_pkg::*;

  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] ddr;
  logic              done;
  logic              send;
  logic [CHAR_W-1:0] tx_data;
  logic              ld_dsr_ext;
  logic [DATA_W-1:0] dsr_ext;
  logic              busy;

  modport master (
    output dsr, ddr, done,
    input  send, tx_data, ld_dsr_ext, dsr_ext, busy
  );

  modport slave (
    input  dsr, ddr, done,
    output send, tx_data, ld_dsr_ext, dsr_ext, busy
  );

endinterface

// File: rtl/uart_tx.sv
// 8N1 serializer: start bit 0, data LSB first, stop bit 1, each bit held
// CLKS_PER_BIT cycles. o_done_c is high in the last cycle of the stop bit.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done_c
);

  localparam int unsigned BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned BIT_W      = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  logic              r_busy;
  logic              r_tx;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [BIT_W-1:0]  r_bit_idx;
  logic [8:0]        r_shift;
  logic              w_bit_end;

  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  // Baud counter, bit counter and shift register for one frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '1;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy     <= 1'b1;
        r_tx       <= 1'b0;
        r_baud_cnt <= '0;
        r_bit_idx  <= '0;
        r_shift    <= {1'b1, i_data};
      end
    end else if (w_bit_end) begin
      r_baud_cnt <= '0;
      if (r_bit_idx == BIT_LAST) begin
        r_busy <= 1'b0;
        r_tx   <= 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx + BIT_W'(1);
        r_tx      <= r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
      end
    end else begin
      r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
    end
  end

  assign o_tx     = r_tx;
  assign o_busy   = r_busy;
  assign o_done_c = r_busy && (r_bit_idx == BIT_LAST) && w_bit_end;

endmodule

// File: rtl/display_output.sv
// LC-3 display output controller: latches DDR when DSR ready is cleared,
// runs a send/done handshake, then pulses a DSR reload with ready set.
// Build option DISPLAY_UART_TX_EN: use the internal uart_tx serializer for
// the done strobe and the tx line instead of the external done input.
module display_output
  import lc3_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  display_output_if.slave   bus,
  output logic              tx
);

  io_state_e         r_state;
  logic              r_send;
  logic              r_ld_dsr_ext;
  logic              r_busy;
  logic [CHAR_W-1:0] r_tx_data;
  logic              w_done;
  logic              w_unused;

`ifdef DISPLAY_UART_TX_EN
  logic w_uart_start;
  logic w_uart_busy;

  // Kick the serializer in the first SEND cycle
  assign w_uart_start = (r_state == SEND) && !w_uart_busy;

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_uart_start),
    .i_data   (r_tx_data),
    .o_tx     (tx),
    .o_busy   (w_uart_busy),
    .o_done_c (w_done)
  );

  assign w_unused = ^{bus.dsr[DATA_W-2:0], bus.ddr[DATA_W-1:CHAR_W], bus.done};
`else
  // External transmitter completes the handshake; serial line stays idle
  assign w_done   = bus.done;
  assign tx       = 1'b1;
  assign w_unused = ^{bus.dsr[DATA_W-2:0], bus.ddr[DATA_W-1:CHAR_W], 32'(CLKS_PER_BIT)};
`endif

  // Sequencer with Moore outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_send       <= 1'b0;
      r_ld_dsr_ext <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_send       <= 1'b0;
      r_ld_dsr_ext <= 1'b0;
      r_busy       <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (!sr_ready(bus.dsr)) begin
            r_state <= LATCH;
          end else begin
            r_busy <= 1'b0;
          end
        end
        LATCH: begin
          r_tx_data <= bus.ddr[CHAR_W-1:0];
          r_send    <= 1'b1;
          r_state   <= SEND;
        end
        SEND: begin
          if (w_done) begin
            r_ld_dsr_ext <= 1'b1;
            r_state      <= SET_READY;
          end else begin
            r_send <= 1'b1;
          end
        end
        SET_READY: begin
          r_state <= SETTLE;
        end
        SETTLE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.send       = r_send;
  assign bus.ld_dsr_ext = r_ld_dsr_ext;
  assign bus.busy       = r_busy;
  assign bus.tx_data    = r_tx_data;
  assign bus.dsr_ext    = DSR_READY_VALUE;

endmodule
